axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter MEM_AW, default 8, log2 of the memory depth in 64-bit words (256 words).
REQ-002 Parameter ERR_ON_BAD_SIZE, default 1, enables SLVERR for non-8-byte sizes.
REQ-003 clk_wr  in  1  single clock; all logic is rising-edge.
REQ-004 rst_wr  in  1  reset, synchronous and active-high.
REQ-005 user_arid  in  4  AR ID.
REQ-006 user_arsize  in  3  AR beat size.
REQ-007 user_arlen  in  8  AR beats minus 1.
REQ-008 user_arburst  in  2  AR burst type.
REQ-009 user_araddr  in  32  AR byte address.
REQ-010 user_arvalid  in  1  AR valid.
REQ-011 user_arready  out  1  AR ready.
REQ-012 user_awid  in  4  AW ID.
REQ-013 user_awsize  in  3  AW beat size.
REQ-014 user_awlen  in  8  AW beats minus 1.
REQ-015 user_awburst  in  2  AW burst type.
REQ-016 user_awaddr  in  32  AW byte address.
REQ-017 user_awvalid  in  1  AW valid.
REQ-018 user_awready  out  1  AW ready.
REQ-019 user_wid  in  4  W ID.
REQ-020 user_wdata  in  64  W data.
REQ-021 user_wstrb  in  16  W strobes; only bits [7:0] are used.
REQ-022 user_wlast  in  1  W last beat.
REQ-023 user_wvalid  in  1  W valid.
REQ-024 user_wready  out  1  W ready.
REQ-025 user_rid  out  4  R ID.
REQ-026 user_rdata  out  64  R data.
REQ-027 user_rlast  out  1  R last beat.
REQ-028 user_rresp  out  2  R response.
REQ-029 user_rvalid  out  1  R valid.
REQ-030 user_rready  in  1  R ready.
REQ-031 user_bid  out  4  B ID.
REQ-032 user_bresp  out  2  B response.
REQ-033 user_bvalid  out  1  B valid.
REQ-034 user_bready  in  1  B ready.

Function
REQ-035 The block SHALL be a far-side AXI slave backed by a 2^MEM_AW x 64-bit register array, with word index = addr[MEM_AW+2:3], wrapping modulo depth.
REQ-036 The block SHALL run a single-transaction FSM with states IDLE, WR_DATA, WR_RESP and RD_DATA; only one transaction is outstanding at a time.
REQ-037 In IDLE, user_awready/user_arready SHALL be combinational grants; when both valids are high, a round-robin flag (reset: write first) SHALL pick one, and the flag SHALL toggle after each grant.
REQ-038 On the AW handshake, the block SHALL latch id/len/burst/index/size and enter WR_DATA.
REQ-039 In WR_DATA, wready SHALL be 1; each W handshake SHALL write the bytes selected by wstrb[7:0] at the current index. The index SHALL advance by 1 for INCR and WRAP and hold for FIXED.
REQ-040 On the W handshake with wlast=1, the block SHALL enter WR_RESP; bvalid SHALL rise on the next cycle, with bid = latched awid.
REQ-041 bresp SHALL be SLVERR (2'b10) if any of the following hold, otherwise OKAY: the beat count is not awlen+1, any wid differs from awid, awburst is WRAP or reserved, or size is not 3 (when ERR_ON_BAD_SIZE=1).
REQ-042 When size is bad, memory writes SHALL be suppressed for the whole burst.
REQ-043 bvalid and bid SHALL hold until bready; the block SHALL return to IDLE on the B handshake.
REQ-044 On the AR handshake, the block SHALL enter RD_DATA; the next cycle SHALL have rvalid=1, rdata=mem[index], rid=arid, and rlast=(arlen==0).
REQ-045 On each R handshake that is not the last beat, rdata SHALL reload from mem[next index] in the same edge; rvalid SHALL stay 1, giving back-to-back beats.
REQ-046 R outputs SHALL hold stable while rready=0.
REQ-047 rresp SHALL follow the REQ-041 burst and size rules on every beat.
REQ-048 The R handshake with rlast=1 SHALL return the FSM to IDLE.
REQ-049 No ready SHALL be asserted for a channel outside its owning state.

Reset
REQ-050 While rst_wr=1, the FSM SHALL go to IDLE and all outputs SHALL be 0; the round-robin flag SHALL select write; reset mid-burst SHALL abandon the transaction with no B/R emitted; memory contents SHALL NOT be reset.

Verification
REQ-051 AW(id=3, addr=0x10, len=3, INCR, size=3) with 4 beats 0xA0..0xA3 and wstrb=0xFF -> one B with bid=3, bresp=OKAY; words 2..5 = 0xA0..0xA3.
REQ-052 AR(id=5, addr=0x10, len=3) with rready held 1 -> 4 consecutive beats 0xA0..0xA3, rlast only on the 4th, rid=5, rresp=OKAY; rready toggled every other cycle -> same data, held stable while rready=0.
REQ-053 AWVALID and ARVALID asserted together from reset, twice -> write granted first, then read.
REQ-054 AW len=1 with wlast on beat 3 -> bresp=SLVERR; AW size=2 -> SLVERR and memory unchanged; wstrb=0x0F -> only the low 4 bytes written.
REQ-055 FIXED AW len=2 with data 1,2,3 -> word holds 3; addr=0x7F8 INCR len=1 -> beats hit words 255 then 0.
REQ-056 rst_wr pulsed during RD_DATA beat 2 -> rvalid=0 the next cycle; a subsequent AR completes normally.

Source files
------------

// File: rtl/axi_mem_responder.sv
// Far-side AXI slave backed by a 64-bit register array; one transaction in
// flight at a time, with round-robin arbitration between AW and AR in IDLE.
module axi_mem_responder #(
  parameter int unsigned MEM_AW          = 8,
  parameter bit          ERR_ON_BAD_SIZE = 1'b1
) (
  input  logic        clk_wr,
  input  logic        rst_wr,
  input  logic [3:0]  user_arid,
  input  logic [2:0]  user_arsize,
  input  logic [7:0]  user_arlen,
  input  logic [1:0]  user_arburst,
  input  logic [31:0] user_araddr,
  input  logic        user_arvalid,
  output logic        user_arready,
  input  logic [3:0]  user_awid,
  input  logic [2:0]  user_awsize,
  input  logic [7:0]  user_awlen,
  input  logic [1:0]  user_awburst,
  input  logic [31:0] user_awaddr,
  input  logic        user_awvalid,
  output logic        user_awready,
  input  logic [3:0]  user_wid,
  input  logic [63:0] user_wdata,
  input  logic [15:0] user_wstrb,
  input  logic        user_wlast,
  input  logic        user_wvalid,
  output logic        user_wready,
  output logic [3:0]  user_rid,
  output logic [63:0] user_rdata,
  output logic        user_rlast,
  output logic [1:0]  user_rresp,
  output logic        user_rvalid,
  input  logic        user_rready,
  output logic [3:0]  user_bid,
  output logic [1:0]  user_bresp,
  output logic        user_bvalid,
  input  logic        user_bready
);

  localparam int unsigned DEPTH       = 1 << MEM_AW;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [3:0]          id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                fixed_q, fixed_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic                err_q, err_d;
  logic                size_ok_q, size_ok_d;
  logic                bvalid_q, bvalid_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [63:0]         rdata_q, rdata_d;

  logic [63:0]         mem_q [DEPTH];

  logic [MEM_AW-1:0]   aw_idx, ar_idx, next_idx;
  logic                idle, aw_gnt, ar_gnt;
  logic                w_hs, b_hs, r_hs;
  logic                mem_we, beat_err;
  logic                aw_size_bad, ar_size_bad;

  assign aw_idx   = user_awaddr[MEM_AW+2:3];
  assign ar_idx   = user_araddr[MEM_AW+2:3];
  assign next_idx = fixed_q ? idx_q : idx_q + MEM_AW'(1);

  assign aw_size_bad = ERR_ON_BAD_SIZE && (user_awsize != 3'd3);
  assign ar_size_bad = ERR_ON_BAD_SIZE && (user_arsize != 3'd3);

  // The round-robin flag only matters when both valids collide; rr_q=0 favours AW.
  assign idle   = (state_q == IDLE) && !rst_wr;
  assign aw_gnt = idle && user_awvalid && (!user_arvalid || !rr_q);
  assign ar_gnt = idle && user_arvalid && (!user_awvalid || rr_q);

  assign user_awready = aw_gnt;
  assign user_arready = ar_gnt;
  assign user_wready  = (state_q == WR_DATA) && !rst_wr;

  assign w_hs   = user_wready && user_wvalid;
  assign b_hs   = bvalid_q && user_bready;
  assign r_hs   = rvalid_q && user_rready;
  assign mem_we = w_hs && size_ok_q;

  assign user_bvalid = bvalid_q;
  assign user_bid    = bvalid_q ? id_q : 4'h0;
  assign user_bresp  = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign user_rvalid = rvalid_q;
  assign user_rid    = rvalid_q ? id_q : 4'h0;
  assign user_rdata  = rdata_q;
  assign user_rlast  = rlast_q;
  assign user_rresp  = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    fixed_d   = fixed_q;
    idx_d     = idx_q;
    err_d     = err_q;
    size_ok_d = size_ok_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    beat_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aw_gnt) begin
          id_d      = user_awid;
          len_d     = user_awlen;
          cnt_d     = '0;
          fixed_d   = (user_awburst == BURST_FIXED);
          idx_d     = aw_idx;
          err_d     = user_awburst[1] || aw_size_bad;
          size_ok_d = !aw_size_bad;
          rr_d      = ~rr_q;
          state_d   = WR_DATA;
        end else if (ar_gnt) begin
          // First beat is fetched at the AR edge; idx then points at beat 2.
          id_d     = user_arid;
          len_d    = user_arlen;
          cnt_d    = user_arlen;
          fixed_d  = (user_arburst == BURST_FIXED);
          idx_d    = (user_arburst == BURST_FIXED) ? ar_idx : ar_idx + MEM_AW'(1);
          err_d    = user_arburst[1] || ar_size_bad;
          rdata_d  = mem_q[ar_idx];
          rvalid_d = 1'b1;
          rlast_d  = (user_arlen == 8'd0);
          rr_d     = ~rr_q;
          state_d  = RD_DATA;
        end
      end

      WR_DATA: begin
        if (w_hs) begin
          // cnt counts accepted beats; wlast must coincide with beat len.
          beat_err = (user_wid != id_q) || (user_wlast != (cnt_q == len_q));
          err_d    = err_q || beat_err;
          cnt_d    = cnt_q + 8'd1;
          idx_d    = next_idx;
          if (user_wlast) begin
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            rdata_d = mem_q[idx_q];
            idx_d   = next_idx;
            cnt_d   = cnt_q - 8'd1;
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      size_ok_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      fixed_q   <= fixed_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      size_ok_q <= size_ok_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_wr) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (user_wstrb[b]) mem_q[idx_q][8*b +: 8] <= user_wdata[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{user_wstrb[15:8], user_awaddr[31:MEM_AW+3], user_awaddr[2:0],
                       user_araddr[31:MEM_AW+3], user_araddr[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;

  logic        clk_wr = 1'b0;
  logic        rst_wr;
  logic [3:0]  user_arid;
  logic [2:0]  user_arsize;
  logic [7:0]  user_arlen;
  logic [1:0]  user_arburst;
  logic [31:0] user_araddr;
  logic        user_arvalid;
  logic        user_arready;
  logic [3:0]  user_awid;
  logic [2:0]  user_awsize;
  logic [7:0]  user_awlen;
  logic [1:0]  user_awburst;
  logic [31:0] user_awaddr;
  logic        user_awvalid;
  logic        user_awready;
  logic [3:0]  user_wid;
  logic [63:0] user_wdata;
  logic [15:0] user_wstrb;
  logic        user_wlast;
  logic        user_wvalid;
  logic        user_wready;
  logic [3:0]  user_rid;
  logic [63:0] user_rdata;
  logic        user_rlast;
  logic [1:0]  user_rresp;
  logic        user_rvalid;
  logic        user_rready;
  logic [3:0]  user_bid;
  logic [1:0]  user_bresp;
  logic        user_bvalid;
  logic        user_bready;

  axi_mem_responder #(.MEM_AW(8), .ERR_ON_BAD_SIZE(1'b1)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
    .user_arburst(user_arburst), .user_araddr(user_araddr),
    .user_arvalid(user_arvalid), .user_arready(user_arready),
    .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
    .user_awburst(user_awburst), .user_awaddr(user_awaddr),
    .user_awvalid(user_awvalid), .user_awready(user_awready),
    .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
    .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
    .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
    .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
    .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
    .user_bready(user_bready)
  );

  always #5 clk_wr = ~clk_wr;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] mdl_mem [256];
  bit          mdl_rr;
  logic [63:0] wq [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_of(input logic [31:0] addr, input int unsigned k,
                                         input logic [1:0] burst);
    int unsigned base;
    base = int'(addr[10:3]);
    if (burst == 2'b00) return base[7:0];
    return 8'((base + k) % 256);
  endfunction

  function automatic bit req_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst >= 2'd2) || (size != 3'd3);
  endfunction

  function automatic void apply_write(input logic [31:0] addr, input logic [1:0] burst,
                                      input logic [2:0] size, input int nbeats,
                                      input logic [7:0] strb);
    logic [7:0] w;
    if (size != 3'd3) return;
    for (int k = 0; k < nbeats; k++) begin
      w = word_of(addr, k, burst);
      for (int b = 0; b < 8; b++)
        if (strb[b]) mdl_mem[w][8*b +: 8] = wq[k][8*b +: 8];
    end
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    bit hs = 0;
    int n = 0;
    user_awid = id; user_awaddr = addr; user_awlen = len;
    user_awburst = burst; user_awsize = size; user_awvalid = 1'b1;
    while (!hs && n < 100) begin
      #1 hs = user_awready;
      @(posedge clk_wr); #1;
      n++;
    end
    user_awvalid = 1'b0;
    check_eq("aw_handshake", hs, 1'b1);
    if (hs) mdl_rr = ~mdl_rr;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    bit hs = 0;
    int n = 0;
    user_arid = id; user_araddr = addr; user_arlen = len;
    user_arburst = burst; user_arsize = size; user_arvalid = 1'b1;
    while (!hs && n < 100) begin
      #1 hs = user_arready;
      @(posedge clk_wr); #1;
      n++;
    end
    user_arvalid = 1'b0;
    check_eq("ar_handshake", hs, 1'b1);
    if (hs) mdl_rr = ~mdl_rr;
  endtask

  task automatic w_send(input logic [3:0] id, input int nbeats, input logic [7:0] strb,
                        input int bad_beat);
    bit hs;
    int n;
    for (int k = 0; k < nbeats; k++) begin
      user_wvalid = 1'b1;
      user_wdata  = wq[k];
      user_wstrb  = {8'($urandom), strb};
      user_wlast  = (k == nbeats - 1);
      user_wid    = (k == bad_beat) ? (id ^ 4'h1) : id;
      // Both address channels are offered during data; neither may be granted.
      user_awvalid = (k == 0);
      user_arvalid = (k == 0);
      hs = 0; n = 0;
      while (!hs && n < 100) begin
        #1 hs = user_wready;
        if (k == 0 && n == 0) begin
          check_eq("awready_in_wr", user_awready, 1'b0);
          check_eq("arready_in_wr", user_arready, 1'b0);
        end
        @(posedge clk_wr); #1;
        n++;
      end
      check_eq("w_handshake", hs, 1'b1);
    end
    user_wvalid = 1'b0; user_wlast = 1'b0;
    user_awvalid = 1'b0; user_arvalid = 1'b0;
    check_eq("b_valid_rise", user_bvalid, 1'b1);
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
    bit         hs;
    logic [3:0] got_id;
    logic [1:0] got_resp;
    int         d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      check_eq("b_hold", {user_bvalid, user_bid}, {1'b1, id});
      @(posedge clk_wr); #1;
    end
    user_bready = 1'b1;
    #1 hs = user_bvalid; got_id = user_bid; got_resp = user_bresp;
    @(posedge clk_wr); #1;
    user_bready = 1'b0;
    check_eq("b_handshake", hs, 1'b1);
    check_eq("bid", got_id, id);
    check_eq("bresp", got_resp, resp);
    check_eq("b_valid_drop", user_bvalid, 1'b0);
  endtask

  task automatic r_recv(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size, input int mode);
    int   k = 0;
    int   cyc = 0;
    bit   rdy;
    logic v;
    while (k <= int'(len) && cyc < 3000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      user_rready = rdy;
      #1 v = user_rvalid;
      check_eq("rvalid", v, 1'b1);
      check_eq("rdata", user_rdata, mdl_mem[word_of(addr, k, burst)]);
      check_eq("rid", user_rid, id);
      check_eq("rresp", user_rresp, req_bad(burst, size) ? 2'b10 : 2'b00);
      check_eq("rlast", user_rlast, (k == int'(len)));
      @(posedge clk_wr); #1;
      if (rdy && v) k++;
      cyc++;
    end
    user_rready = 1'b0;
    check_eq("r_beats_done", k, int'(len) + 1);
    check_eq("r_valid_drop", user_rvalid, 1'b0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                          input logic [7:0] strb, input int bad_beat);
    bit err;
    err = req_bad(burst, size) || (nbeats != int'(len) + 1) ||
          (bad_beat >= 0 && bad_beat < nbeats);
    aw_send(id, addr, len, burst, size);
    w_send(id, nbeats, strb, bad_beat);
    b_recv(id, err ? 2'b10 : 2'b00);
    apply_write(addr, burst, size, nbeats, strb);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode);
    ar_send(id, addr, len, burst, size);
    r_recv(id, addr, len, burst, size, mode);
  endtask

  task automatic arb_pair(input logic [31:0] addr);
    bit gw = 0, gr = 0;
    int n = 0;
    user_awid = 4'h1; user_awaddr = addr; user_awlen = 8'd0; user_awburst = 2'b01;
    user_awsize = 3'd3; user_awvalid = 1'b1;
    user_arid = 4'h2; user_araddr = addr; user_arlen = 8'd0; user_arburst = 2'b01;
    user_arsize = 3'd3; user_arvalid = 1'b1;
    while (!gw && !gr && n < 20) begin
      #1 gw = user_awready; gr = user_arready;
      @(posedge clk_wr); #1;
      n++;
    end
    user_awvalid = 1'b0; user_arvalid = 1'b0;
    check_eq("arb_aw_grant", gw, !mdl_rr);
    check_eq("arb_ar_grant", gr, mdl_rr);
    mdl_rr = ~mdl_rr;
    if (gw) begin
      wq.delete(); wq.push_back({$urandom, $urandom});
      w_send(4'h1, 1, 8'hFF, -1);
      b_recv(4'h1, 2'b00);
      apply_write(addr, 2'b01, 3'd3, 1, 8'hFF);
    end else if (gr) begin
      r_recv(4'h2, addr, 8'd0, 2'b01, 3'd3, 0);
    end
  endtask

  task automatic release_reset();
    user_awvalid = 1'b0; user_arvalid = 1'b0; user_wvalid = 1'b0;
    user_rready = 1'b0; user_bready = 1'b0;
    rst_wr = 1'b0; mdl_rr = 1'b0;
    @(posedge clk_wr); #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_wr = 1'b1;
    user_arid = '0; user_arsize = 3'd3; user_arlen = '0; user_arburst = 2'b01;
    user_araddr = '0; user_awid = '0; user_awsize = 3'd3; user_awlen = '0;
    user_awburst = 2'b01; user_awaddr = '0; user_wid = '0; user_wdata = '0;
    user_wstrb = '0; user_wlast = 1'b0; user_wvalid = 1'b1;
    user_rready = 1'b1; user_bready = 1'b1;
    user_awvalid = 1'b1; user_arvalid = 1'b1;
    repeat (3) @(posedge clk_wr);
    #1;
    check_eq("rst_awready", user_awready, 1'b0);
    check_eq("rst_arready", user_arready, 1'b0);
    check_eq("rst_wready", user_wready, 1'b0);
    check_eq("rst_bvalid", user_bvalid, 1'b0);
    check_eq("rst_rvalid", user_rvalid, 1'b0);
    check_eq("rst_routs", {user_rdata, user_rid, user_rlast, user_rresp}, '0);
    check_eq("rst_bouts", {user_bid, user_bresp}, '0);
    release_reset();

    // Simultaneous AW/AR from reset: write first, then read.
    arb_pair(32'h40);
    arb_pair(32'h40);

    // Fill the whole array so every later read has a known expectation.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back({$urandom, $urandom});
    do_write(4'h0, 32'h0, 8'd255, 2'b01, 3'd3, 256, 8'hFF, -1);

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(64'hA0 + 64'(i));
    do_write(4'd3, 32'h10, 8'd3, 2'b01, 3'd3, 4, 8'hFF, -1);
    check_eq("word2_a0", mdl_mem[2], 64'hA0);
    check_eq("word5_a3", mdl_mem[5], 64'hA3);
    do_read(4'd5, 32'h10, 8'd3, 2'b01, 3'd3, 0);
    do_read(4'd5, 32'h10, 8'd3, 2'b01, 3'd3, 1);

    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back({$urandom, $urandom});
    do_write(4'd1, 32'h100, 8'd1, 2'b01, 3'd3, 3, 8'hFF, -1);
    do_read(4'd1, 32'h100, 8'd2, 2'b01, 3'd3, 0);
    do_write(4'd2, 32'h200, 8'd1, 2'b01, 3'd2, 2, 8'hFF, -1);
    do_read(4'd2, 32'h200, 8'd1, 2'b01, 3'd3, 0);
    do_write(4'd4, 32'h300, 8'd0, 2'b01, 3'd3, 1, 8'h0F, -1);
    do_read(4'd4, 32'h300, 8'd0, 2'b01, 3'd3, 0);
    do_write(4'd6, 32'h340, 8'd2, 2'b01, 3'd3, 3, 8'hFF, 1);
    do_write(4'd7, 32'h380, 8'd1, 2'b10, 3'd3, 2, 8'hFF, -1);
    do_read(4'd7, 32'h380, 8'd1, 2'b10, 3'd3, 0);
    do_read(4'd8, 32'h380, 8'd1, 2'b01, 3'd1, 2);
    do_read(4'd9, 32'h380, 8'd0, 2'b11, 3'd3, 0);

    wq.delete();
    for (int i = 1; i <= 3; i++) wq.push_back(64'(i));
    do_write(4'd2, 32'h500, 8'd2, 2'b00, 3'd3, 3, 8'hFF, -1);
    check_eq("fixed_word", mdl_mem[8'hA0], 64'd3);
    do_read(4'd2, 32'h500, 8'd0, 2'b01, 3'd3, 0);
    do_read(4'd2, 32'h500, 8'd2, 2'b00, 3'd3, 1);
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back({$urandom, $urandom});
    do_write(4'd3, 32'h7F8, 8'd1, 2'b01, 3'd3, 2, 8'hFF, -1);
    do_read(4'd3, 32'h7F8, 8'd1, 2'b01, 3'd3, 0);
    do_read(4'd3, 32'h0, 8'd0, 2'b01, 3'd3, 0);

    // Reset while the second read beat is on the bus.
    ar_send(4'd7, 32'h10, 8'd3, 2'b01, 3'd3);
    user_rready = 1'b1;
    #1 check_eq("rst_mid_beat0", user_rdata, mdl_mem[2]);
    @(posedge clk_wr); #1;
    check_eq("rst_mid_beat1", user_rdata, mdl_mem[3]);
    rst_wr = 1'b1; user_rready = 1'b0;
    @(posedge clk_wr); #1;
    check_eq("rst_mid_rvalid", user_rvalid, 1'b0);
    check_eq("rst_mid_bvalid", user_bvalid, 1'b0);
    release_reset();
    check_eq("post_rst_rvalid", user_rvalid, 1'b0);
    arb_pair(32'h600);
    arb_pair(32'h600);
    do_read(4'd8, 32'h10, 8'd3, 2'b01, 3'd3, 0);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [3:0]  id;
      int          nb, sel, bad;
      a     = $urandom;
      len   = 8'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      id    = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 7);
        nb  = int'(len) + 1;
        if (sel == 0) nb = int'(len) + 2;
        if (sel == 1 && len > 0) nb = int'(len);
        bad = (sel == 2) ? $urandom_range(0, nb - 1) : -1;
        wq.delete();
        for (int i = 0; i < nb; i++) wq.push_back({$urandom, $urandom});
        do_write(id, a, len, burst, size, nb, 8'($urandom), bad);
      end else begin
        do_read(id, a, len, burst, size, $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
